spim_wb: RTL and testbench

Wishbone SPI master that replaces CPU bit-banging on the dedicated SD-card SPI bus with a hardware byte engine. The CPU pushes bytes into a 4-entry TX FIFO. A mode-0 shifter clocks each byte out on sd_mosi while capturing sd_miso into a 4-entry RX FIFO. Chip select remains under direct software control. The block sits between the SoC Wishbone bus and the SD card pins.

---
 rtl/spim_pkg.sv | 23 ++
 rtl/spim_fifo.sv | 58 +++++
 rtl/spim_wb.sv | 205 ++++++++++++++++++++
 tb/tb_spim_wb.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spim_pkg.sv
// Shared definitions for the Wishbone SPI master: register map, STATUS bit
// positions and the shifter state encoding.
package spim_pkg;

    localparam logic [1:0] SPIM_DATA   = 2'd0;
    localparam logic [1:0] SPIM_STATUS = 2'd1;
    localparam logic [1:0] SPIM_CTRL   = 2'd2;

    localparam int ST_BUSY     = 0;
    localparam int ST_TX_EMPTY = 1;
    localparam int ST_TX_FULL  = 2;
    localparam int ST_RX_EMPTY = 3;
    localparam int ST_RX_FULL  = 4;
    localparam int ST_RX_OVF   = 5;
    localparam int ST_TX_OVF   = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2
    } spim_state_t;

endpackage

// File: rtl/spim_fifo.sv
// Byte-wide synchronous FIFO with first-word-fall-through output; a push
// into a full FIFO is only accepted when a pop frees a slot in the same cycle.
module spim_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/spim_wb.sv
// Wishbone SPI master for the SD-card bus: TX/RX byte FIFOs feeding a mode-0
// shifter with a programmable half-period divider and software chip select.
module spim_wb
    import spim_pkg::*;
#(
    parameter int         DEPTH   = 4,
    parameter logic [7:0] DIV_RST = 8'd49
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic        wb_we_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    output logic        wb_ack_o,
    output logic        sd_ss,
    output logic        sd_sck,
    output logic        sd_mosi,
    input  logic        sd_miso
);

    logic        access;
    logic        bus_wr;
    logic        bus_rd;
    logic [1:0]  reg_sel;
    logic        tx_push, tx_pop, tx_full, tx_empty;
    logic        rx_push, rx_pop, rx_full, rx_empty;
    logic [7:0]  tx_dout, rx_dout, rx_byte;
    logic        ss, tx_ovf, rx_ovf;
    logic [7:0]  div;
    spim_state_t state, state_next;
    logic [7:0]  div_cnt;
    logic [2:0]  bit_cnt;
    logic [7:0]  tx_sh, rx_sh;
    logic        sck, mosi, miso_q;
    logic        half_done, busy;
    logic [6:0]  status;
    logic [31:0] rdata;
    logic        unused_bits;

    assign access  = wb_cyc_i & wb_stb_i & ~wb_ack_o;
    assign bus_wr  = access & wb_we_i;
    assign bus_rd  = access & ~wb_we_i;
    assign reg_sel = wb_adr_i[3:2];
    assign tx_push = bus_wr && (reg_sel == SPIM_DATA);
    assign rx_pop  = bus_rd && (reg_sel == SPIM_DATA);

    assign unused_bits = ^{wb_sel_i, wb_adr_i[31:4], wb_adr_i[1:0], wb_dat_i[31:16],
                           tx_sh[7], rx_sh[7]};

    spim_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
        .clk(wb_clk_i), .rst(wb_rst_i), .push(tx_push), .pop(tx_pop),
        .din(wb_dat_i[7:0]), .dout(tx_dout), .full(tx_full), .empty(tx_empty)
    );

    spim_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
        .clk(wb_clk_i), .rst(wb_rst_i), .push(rx_push), .pop(rx_pop),
        .din(rx_byte), .dout(rx_dout), .full(rx_full), .empty(rx_empty)
    );

    assign busy      = !((state == IDLE) && tx_empty);
    assign half_done = (div_cnt >= div);
    assign rx_byte   = {rx_sh[6:0], miso_q};

    always_comb begin
        status = '0;
        status[ST_BUSY]     = busy;
        status[ST_TX_EMPTY] = tx_empty;
        status[ST_TX_FULL]  = tx_full;
        status[ST_RX_EMPTY] = rx_empty;
        status[ST_RX_FULL]  = rx_full;
        status[ST_RX_OVF]   = rx_ovf;
        status[ST_TX_OVF]   = tx_ovf;
    end

    always_comb begin
        rdata = '0;
        case (reg_sel)
            SPIM_DATA:   rdata = {24'h0, rx_empty ? 8'h00 : rx_dout};
            SPIM_STATUS: rdata = {25'h0, status};
            SPIM_CTRL:   rdata = {16'h0, div, 7'h0, ss};
            default:     rdata = '0;
        endcase
    end

    // Overflow flags: a set in the same cycle as a software clear wins.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wb_ack_o <= 1'b0;
            wb_dat_o <= '0;
            ss       <= 1'b1;
            div      <= DIV_RST;
            tx_ovf   <= 1'b0;
            rx_ovf   <= 1'b0;
        end else begin
            wb_ack_o <= access;
            wb_dat_o <= bus_rd ? rdata : '0;
            if (bus_wr && (reg_sel == SPIM_CTRL)) begin
                ss  <= wb_dat_i[0];
                div <= wb_dat_i[15:8];
            end
            if (bus_wr && (reg_sel == SPIM_STATUS)) begin
                if (wb_dat_i[ST_RX_OVF]) rx_ovf <= 1'b0;
                if (wb_dat_i[ST_TX_OVF]) tx_ovf <= 1'b0;
            end
            if (tx_push && tx_full && !tx_pop) tx_ovf <= 1'b1;
            if (rx_push && rx_full && !rx_pop) rx_ovf <= 1'b1;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        tx_pop     = 1'b0;
        rx_push    = 1'b0;
        case (state)
            IDLE: begin
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    state_next = LOW;
                end
            end
            LOW: begin
                if (half_done) state_next = HIGH;
            end
            HIGH: begin
                if (half_done) begin
                    if (bit_cnt == 3'd7) begin
                        rx_push    = 1'b1;
                        state_next = IDLE;
                    end else begin
                        state_next = LOW;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Shift datapath; the >= compare lets a mid-byte div decrease end the
    // current half-period instead of wrapping the counter.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            div_cnt <= '0;
            bit_cnt <= '0;
            tx_sh   <= '0;
            rx_sh   <= '0;
            sck     <= 1'b0;
            mosi    <= 1'b1;
            miso_q  <= 1'b0;
        end else begin
            miso_q <= sd_miso;
            case (state)
                IDLE: begin
                    if (tx_pop) begin
                        tx_sh   <= tx_dout;
                        mosi    <= tx_dout[7];
                        div_cnt <= '0;
                        bit_cnt <= '0;
                    end
                end
                LOW: begin
                    if (half_done) begin
                        sck     <= 1'b1;
                        div_cnt <= '0;
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                HIGH: begin
                    if (half_done) begin
                        sck     <= 1'b0;
                        div_cnt <= '0;
                        rx_sh   <= rx_byte;
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            mosi <= 1'b1;
                        end else begin
                            mosi  <= tx_sh[6];
                            tx_sh <= {tx_sh[6:0], 1'b0};
                        end
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sd_ss   = ss;
    assign sd_sck  = sck;
    assign sd_mosi = mosi;

endmodule

// File: tb/tb_spim_wb.sv
// Self-checking bench for spim_wb: register table, SPI timing monitor,
// hand-written overflow/reset sequences and randomized loopback rounds.
module tb_spim_wb;
    import spim_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] wb_adr, wb_dat_w, wb_dat_r;
    logic        wb_we, wb_stb, wb_cyc, wb_ack;
    logic [3:0]  wb_sel;
    logic        ss_pin, sck_pin, mosi_pin, miso_pin;
    logic        loopback, miso_val;

    int tests = 0;
    int fails = 0;
    int cyc_count = 0;

    int   rise_q[$];
    int   fall_q[$];
    logic mosi_q[$];
    logic sck_prev = 1'b0;

    typedef struct {
        logic        we;
        logic [1:0]  idx;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[14];

    always #5 clk = ~clk;
    always @(posedge clk) cyc_count <= cyc_count + 1;

    assign miso_pin = loopback ? mosi_pin : miso_val;

    spim_wb #(.DEPTH(DEPTH), .DIV_RST(8'd49)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(wb_adr), .wb_dat_i(wb_dat_w),
        .wb_dat_o(wb_dat_r), .wb_we_i(wb_we), .wb_sel_i(wb_sel), .wb_stb_i(wb_stb),
        .wb_cyc_i(wb_cyc), .wb_ack_o(wb_ack), .sd_ss(ss_pin), .sd_sck(sck_pin),
        .sd_mosi(mosi_pin), .sd_miso(miso_pin)
    );

    // SPI edge monitor, sampled mid-cycle so the cycle count is settled.
    always @(negedge clk) begin
        if (sck_pin && !sck_prev) begin
            rise_q.push_back(cyc_count);
            mosi_q.push_back(mosi_pin);
        end
        if (!sck_pin && sck_prev) fall_q.push_back(cyc_count);
        sck_prev = sck_pin;
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation still running, required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    task automatic clear_monitor();
        rise_q.delete();
        fall_q.delete();
        mosi_q.delete();
    endtask

    task automatic bus_access(input logic write, input logic [1:0] idx, input logic [31:0] wdata,
                              output logic [31:0] rdata, output int acc_cycle);
        bit got = 0;
        @(posedge clk);
        #1;
        wb_cyc   = 1'b1;
        wb_stb   = 1'b1;
        wb_we    = write;
        wb_adr   = ($urandom() & 32'hFFFF_FFF3) | {28'h0, idx, 2'b00};
        wb_dat_w = wdata;
        wb_sel   = 4'($urandom());
        rdata    = '0;
        acc_cycle = 0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(posedge clk);
            #1;
            if (wb_ack) begin
                got       = 1;
                rdata     = wb_dat_r;
                acc_cycle = cyc_count;
            end
        end
        wb_cyc = 1'b0;
        wb_stb = 1'b0;
        wb_we  = 1'b0;
        if (!got) begin
            tests++;
            fails++;
            $display("[TB] FAIL ack_timeout: got no ack, required ack within 8 cycles");
        end
    endtask

    task automatic wb_write(input logic [1:0] idx, input logic [31:0] data, output int acc);
        logic [31:0] dummy;
        bus_access(1'b1, idx, data, dummy, acc);
    endtask

    task automatic wb_read(input logic [1:0] idx, output logic [31:0] data);
        int acc;
        bus_access(1'b0, idx, 32'h0, data, acc);
    endtask

    task automatic apply_stimulus(input vec_t v, input int n);
        logic [31:0] r;
        int acc;
        if (v.we) begin
            wb_write(v.idx, v.wdata, acc);
        end else begin
            wb_read(v.idx, r);
            check_output($sformatf("table_%0d", n), r, v.exp);
        end
    endtask

    task automatic wait_idle(input int max_polls);
        logic [31:0] s;
        bit done = 0;
        for (int i = 0; i < max_polls && !done; i++) begin
            wb_read(SPIM_STATUS, s);
            if (!s[ST_BUSY]) done = 1;
        end
        check_output("idle_reached", 32'(done), 32'd1);
    endtask

    function automatic logic [31:0] status_word(bit busy, bit txe, bit txf, bit rxe, bit rxf,
                                                bit rxo, bit txo);
        return {25'h0, txo, rxo, rxf, rxe, txf, txe, busy};
    endfunction

    // Checks one byte's SCK edges and MOSI bits against the mode-0 timing rules.
    task automatic check_byte(input string name, input logic [7:0] tx, input int dv, input int acc);
        logic [7:0] bits;
        int bad;
        bits = '0;
        bad  = 0;
        check_output({name, "_rises"}, 32'(rise_q.size()), 32'd8);
        check_output({name, "_falls"}, 32'(fall_q.size()), 32'd8);
        if (rise_q.size() == 8 && fall_q.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                bits = {bits[6:0], mosi_q[i]};
                if (fall_q[i] - rise_q[i] != dv + 1) bad++;
                if (i < 7 && rise_q[i+1] - fall_q[i] != dv + 1) bad++;
            end
            check_output({name, "_mosi"}, {24'h0, bits}, {24'h0, tx});
            check_output({name, "_first_rise"}, 32'(rise_q[0]), 32'(acc + 1 + (dv + 1)));
            check_output({name, "_done"}, 32'(fall_q[7]), 32'(acc + 1 + 16 * (dv + 1)));
            check_output({name, "_half_periods"}, 32'(bad), 32'd0);
        end
    endtask

    initial begin
        logic [31:0] r;
        logic [3:0]  pat;
        int          acc;
        int          bad;
        logic [7:0]  sent[$];
        logic [7:0]  rx_model[$];
        bit          rx_ovf_m;
        logic [7:0]  b;
        logic [7:0]  exp_b;
        int          k, nreads, dv;

        rst = 1'b1; wb_cyc = 0; wb_stb = 0; wb_we = 0; wb_adr = '0; wb_dat_w = '0; wb_sel = '0;
        loopback = 1'b1; miso_val = 1'b0;

        vecs[0]  = '{1'b0, SPIM_STATUS, 32'h0,         32'h0000_000A};
        vecs[1]  = '{1'b0, SPIM_CTRL,   32'h0,         32'h0000_3101};
        vecs[2]  = '{1'b0, 2'd3,        32'h0,         32'h0};
        vecs[3]  = '{1'b0, SPIM_DATA,   32'h0,         32'h0};
        vecs[4]  = '{1'b1, SPIM_CTRL,   32'h0000_0200, 32'h0};
        vecs[5]  = '{1'b0, SPIM_CTRL,   32'h0,         32'h0000_0200};
        vecs[6]  = '{1'b1, 2'd3,        32'hFFFF_FFFF, 32'h0};
        vecs[7]  = '{1'b0, 2'd3,        32'h0,         32'h0};
        vecs[8]  = '{1'b1, SPIM_CTRL,   32'hFFFF_FF01, 32'h0};
        vecs[9]  = '{1'b0, SPIM_CTRL,   32'h0,         32'h0000_FF01};
        vecs[10] = '{1'b1, SPIM_STATUS, 32'h0000_0060, 32'h0};
        vecs[11] = '{1'b0, SPIM_STATUS, 32'h0,         32'h0000_000A};
        vecs[12] = '{1'b1, SPIM_CTRL,   32'h0000_0000, 32'h0};
        vecs[13] = '{1'b0, SPIM_CTRL,   32'h0,         32'h0};

        repeat (3) @(posedge clk);
        #1;
        check_output("rst_ss", 32'(ss_pin), 32'd1);
        check_output("rst_sck", 32'(sck_pin), 32'd0);
        check_output("rst_mosi", 32'(mosi_pin), 32'd1);
        check_output("rst_ack", 32'(wb_ack), 32'd0);
        check_output("rst_dat", wb_dat_r, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) apply_stimulus(vecs[i], i);
        check_output("ss_low", 32'(ss_pin), 32'd0);

        // Holding the strobe: ack must pulse for one cycle, then re-accept.
        @(posedge clk);
        #1;
        wb_cyc = 1; wb_stb = 1; wb_we = 0; wb_adr = {28'h0, SPIM_STATUS, 2'b00};
        pat = '0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            pat = {pat[2:0], wb_ack};
        end
        wb_cyc = 0; wb_stb = 0;
        check_output("ack_pattern", {28'h0, pat}, 32'h0000_000A);

        // Single byte, div=0, MISO looped to MOSI.
        clear_monitor();
        wb_write(SPIM_DATA, 32'h0000_00A5, acc);
        wait_idle(50);
        check_byte("loop_a5", 8'hA5, 0, acc);
        wb_read(SPIM_DATA, r);
        check_output("loop_a5_rx", r, 32'h0000_00A5);
        wb_read(SPIM_STATUS, r);
        check_output("loop_status", r, 32'h0000_000A);

        // Fixed MISO low, div=3.
        wb_write(SPIM_CTRL, 32'h0000_0300, acc);
        loopback = 1'b0; miso_val = 1'b0;
        clear_monitor();
        wb_write(SPIM_DATA, 32'h0000_00FF, acc);
        wait_idle(200);
        check_byte("div3_ff", 8'hFF, 3, acc);
        wb_read(SPIM_DATA, r);
        check_output("div3_rx", r, 32'h0);
        loopback = 1'b1;

        // RX overflow: five back-to-back bytes, no reads until done.
        wb_write(SPIM_CTRL, 32'h0, acc);
        clear_monitor();
        for (int i = 1; i <= 5; i++) wb_write(SPIM_DATA, 32'(i * 8'h11), acc);
        wait_idle(200);
        check_output("b2b_rises", 32'(rise_q.size()), 32'd40);
        bad = 0;
        if (rise_q.size() == 40 && fall_q.size() == 40) begin
            for (int j = 1; j < 5; j++) if (rise_q[8*j] - fall_q[8*j-1] != 2) bad++;
        end
        check_output("b2b_gap", 32'(bad), 32'd0);
        wb_read(SPIM_STATUS, r);
        check_output("rxovf_status", r, status_word(0, 1, 0, 0, 1, 1, 0));
        for (int i = 1; i <= 5; i++) begin
            wb_read(SPIM_DATA, r);
            check_output($sformatf("rxovf_read_%0d", i), r, (i <= 4) ? 32'(i * 8'h11) : 32'h0);
        end
        wb_read(SPIM_STATUS, r);
        check_output("rxovf_drained", r, status_word(0, 1, 0, 1, 0, 1, 0));
        wb_write(SPIM_STATUS, 32'h20, acc);
        wb_read(SPIM_STATUS, r);
        check_output("rxovf_cleared", r, 32'h0000_000A);

        // Randomized loopback rounds against a queue model of the RX FIFO.
        rx_ovf_m = 0;
        for (int rnd = 0; rnd < 20; rnd++) begin
            dv = $urandom_range(0, 2);
            wb_write(SPIM_CTRL, {16'h0, 8'(dv), 8'h00}, acc);
            k = $urandom_range(1, 4);
            sent.delete();
            for (int j = 0; j < k; j++) begin
                b = 8'($urandom());
                sent.push_back(b);
                wb_write(SPIM_DATA, {24'h0, b}, acc);
            end
            wait_idle(300);
            foreach (sent[j]) begin
                if (rx_model.size() < DEPTH) rx_model.push_back(sent[j]);
                else rx_ovf_m = 1;
            end
            wb_read(SPIM_STATUS, r);
            check_output($sformatf("rnd%0d_status", rnd), r,
                         status_word(0, 1, 0, rx_model.size() == 0, rx_model.size() == DEPTH,
                                     rx_ovf_m, 0));
            nreads = $urandom_range(0, 5);
            for (int j = 0; j < nreads; j++) begin
                exp_b = (rx_model.size() > 0) ? rx_model.pop_front() : 8'h00;
                wb_read(SPIM_DATA, r);
                check_output($sformatf("rnd%0d_read%0d", rnd, j), r, {24'h0, exp_b});
            end
            if ($urandom_range(0, 3) == 0) begin
                wb_write(SPIM_STATUS, 32'h20, acc);
                rx_ovf_m = 0;
            end
        end

        // TX overflow at div=255: the first byte moves straight into the
        // shifter, so the sixth write is the first to find the FIFO full.
        wb_write(SPIM_CTRL, 32'h0000_FF00, acc);
        for (int i = 0; i < 6; i++) wb_write(SPIM_DATA, 32'h0000_003C, acc);
        wb_read(SPIM_STATUS, r);
        check_output("txovf_status", {24'h0, r[7:0]} & 32'h45, 32'h45);
        wb_write(SPIM_STATUS, 32'h40, acc);
        wb_read(SPIM_STATUS, r);
        check_output("txovf_cleared", {24'h0, r[7:0]} & 32'h45, 32'h05);

        // Reset while SCK is high.
        for (int i = 0; i < 1000 && !sck_pin; i++) begin
            @(posedge clk);
            #1;
        end
        check_output("reached_high", 32'(sck_pin), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_output("midrst_sck", 32'(sck_pin), 32'd0);
        check_output("midrst_ss", 32'(ss_pin), 32'd1);
        check_output("midrst_mosi", 32'(mosi_pin), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        wb_read(SPIM_STATUS, r);
        check_output("midrst_status", r, 32'h0000_000A);
        wb_read(SPIM_CTRL, r);
        check_output("midrst_ctrl", r, 32'h0000_3101);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
